// File: rtl/cmd_issuer_pkg.sv
// rtl/cmd_issuer_pkg.sv - shared types and opcode encoding for the SIMD PE command issuer
package cmd_issuer_pkg;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        opcode_t;

  // Must track the PE decoder; opcode 0 is the idle/finish-acknowledge word.
  localparam opcode_t INSTR_LD    = 2'b01;
  localparam opcode_t INSTR_INFO  = 2'b10;
  localparam opcode_t INSTR_STORE = 2'b11;

  typedef struct packed {
    opcode_t opcode;
    addr_t   payload;
  } instr_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    addr_t            src0;
    addr_t            src1;
    addr_t            dst;
  } cmd_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
  } instr_info_t;

  function automatic addr_t info_payload(input cmd_t c);
    instr_info_t info;
    info.op    = c.op;
    info.count = c.count;
    return addr_t'(info);
  endfunction

endpackage

// File: rtl/cmd_issuer_if.sv
// rtl/cmd_issuer_if.sv - instruction port between the issuer (master) and the PE (slave)
interface cmd_issuer_if;
  import cmd_issuer_pkg::*;

  logic   o_en;
  instr_t o_instr;
  logic   o_valid;
  logic   i_ack;
  logic   i_busy;
  logic   i_finish;

  modport master (output o_en, o_instr, o_valid, input i_ack, i_busy, i_finish);
  modport slave  (input o_en, o_instr, o_valid, output i_ack, i_busy, i_finish);

endinterface

// File: rtl/cmd_issuer_fifo.sv
// rtl/cmd_issuer_fifo.sv - command queue with wrap-bit pointers and head read from storage
module cmd_fifo
  import cmd_issuer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_head  = mem[rd_ptr[AW-1:0]];
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - queues scheduler commands and serialises setup words to one SIMD PE; CMD_ISSUER_PERF_EN adds latency/retire counters
module cmd_issuer
  import cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cmd_valid,
  input  cmd_t               i_cmd,
  output logic               o_cmd_ready,
  cmd_issuer_if.master       pe,
  output logic               o_done,
  output logic               o_err,
`ifdef CMD_ISSUER_PERF_EN
  output logic [31:0]        o_lat,
  output logic [31:0]        o_retired,
`endif
  output logic               o_idle
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_LD0   = 3'd2;
  localparam logic [2:0] S_LD1   = 3'd3;
  localparam logic [2:0] S_INFO  = 3'd4;
  localparam logic [2:0] S_ST    = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;
  localparam logic [2:0] S_FACK  = 3'd7;

  logic [2:0] state;
  logic       gap;
  cmd_t       cmd_q;
  cmd_t       head;
  logic       full;
  logic       empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic       xfer;

  assign o_cmd_ready = !full;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign push        = accept && (i_cmd.count != '0);
  assign pop         = (state == S_IDLE) && !empty && !pe.i_busy;
  assign xfer        = pe.o_valid && pe.i_ack;
  assign o_idle      = empty && (state == S_IDLE);

  cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (push),
    .i_data  (i_cmd),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (full),
    .o_empty (empty)
  );

  // gap forces o_valid low for one cycle after each setup transfer so a held ack cannot retire two words.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
      gap   <= 1'b0;
      cmd_q <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= accept && (i_cmd.count == '0);
      gap   <= 1'b0;
      case (state)
        S_IDLE:  if (pop) begin
                   cmd_q <= head;
                   state <= S_START;
                 end
        S_START: state <= S_LD0;
        S_LD0:   if (xfer) begin state <= S_LD1;  gap <= 1'b1; end
        S_LD1:   if (xfer) begin state <= S_INFO; gap <= 1'b1; end
        S_INFO:  if (xfer) begin state <= S_ST;   gap <= 1'b1; end
        S_ST:    if (xfer) state <= S_WAIT;
        S_WAIT:  if (pe.i_finish) state <= S_FACK;
        S_FACK:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pe.o_en    = (state == S_START);
    pe.o_valid = 1'b0;
    pe.o_instr = '0;
    o_done     = 1'b0;
    case (state)
      S_LD0:  begin pe.o_valid = !gap; pe.o_instr = '{opcode: INSTR_LD,    payload: cmd_q.src0};          end
      S_LD1:  begin pe.o_valid = !gap; pe.o_instr = '{opcode: INSTR_LD,    payload: cmd_q.src1};          end
      S_INFO: begin pe.o_valid = !gap; pe.o_instr = '{opcode: INSTR_INFO,  payload: info_payload(cmd_q)}; end
      S_ST:   begin pe.o_valid = !gap; pe.o_instr = '{opcode: INSTR_STORE, payload: cmd_q.dst};           end
      S_FACK: begin pe.o_valid = 1'b1; o_done = 1'b1; end
      default: ;
    endcase
  end

`ifdef CMD_ISSUER_PERF_EN
  logic [31:0] lat_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lat_cnt   <= '0;
      o_lat     <= '0;
      o_retired <= '0;
    end else begin
      lat_cnt <= (state == S_START) ? 32'd0 : lat_cnt + 32'd1;
      if (state == S_FACK) begin
        o_lat     <= lat_cnt;
        o_retired <= o_retired + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - directed scoreboard bench for cmd_issuer
module tb_cmd_issuer;
  import cmd_issuer_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_cmd_valid;
  cmd_t        i_cmd;
  logic        o_cmd_ready;
  logic        o_done;
  logic        o_err;
  logic        o_idle;
`ifdef CMD_ISSUER_PERF_EN
  logic [31:0] o_lat;
  logic [31:0] o_retired;
`endif

  cmd_issuer_if pe();

  cmd_issuer #(.DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd       (i_cmd),
    .o_cmd_ready (o_cmd_ready),
    .pe          (pe),
    .o_done      (o_done),
    .o_err       (o_err),
`ifdef CMD_ISSUER_PERF_EN
    .o_lat       (o_lat),
    .o_retired   (o_retired),
`endif
    .o_idle      (o_idle)
  );

  always #5 clk = ~clk;

  instr_t exp_q[$];
  instr_t exp_w;
  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int en_cyc = 0;
  int st_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (pe.o_en) begin en_cnt++; en_cyc = cyc; end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      if (pe.o_valid && (pe.i_ack || o_done)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_word observed=%h expected=none", pe.o_instr);
        end else begin
          exp_w = exp_q.pop_front();
          assert (pe.o_instr === exp_w) else begin
            errors++;
            $error("FAIL word observed=%h expected=%h", pe.o_instr, exp_w);
          end
          checks++;
          assert (o_done === (exp_w == '0)) else begin
            errors++;
            $error("FAIL done_with_ack observed=%b expected=%b", o_done, exp_w == '0);
          end
          if (exp_w.opcode == INSTR_STORE) st_cyc = cyc;
          if (exp_w != '0) xfer_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [1:0] op, input logic [15:0] cnt,
                              input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] d);
    cmd_t c;
    c.op = op; c.count = cnt; c.src0 = s0; c.src1 = s1; c.dst = d;
    return c;
  endfunction

  task automatic add_exp(input cmd_t c);
    exp_q.push_back('{opcode: INSTR_LD,    payload: c.src0});
    exp_q.push_back('{opcode: INSTR_LD,    payload: c.src1});
    exp_q.push_back('{opcode: INSTR_INFO,  payload: {14'b0, c.op, c.count}});
    exp_q.push_back('{opcode: INSTR_STORE, payload: c.dst});
    exp_q.push_back('0);
  endtask

  task automatic push_cmd(input cmd_t c);
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd = c;
    while (!o_cmd_ready && n < 200) begin tick(); n++; end
    chk("push_ready", 64'(o_cmd_ready), 64'd1);
    if (c.count != 0) add_exp(c);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_xfer(input int target);
    int n = 0;
    while (xfer_cnt < target && n < 200) begin tick(); n++; end
    chk("wait_xfer", 64'(xfer_cnt), 64'(target));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!pe.o_valid && n < 50) begin tick(); n++; end
    chk("wait_valid", 64'(pe.o_valid), 64'd1);
  endtask

  task automatic finish_pulse();
    pe.i_finish = 1'b1;
    tick();
    pe.i_finish = 1'b0;
  endtask

  task automatic retire();
    tick();
    tick();
    finish_pulse();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    cmd_t cq[6];
    int base;
    int en0;
    int d0;
    rstn = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd = '0;
    pe.i_ack = 1'b0;
    pe.i_busy = 1'b0;
    pe.i_finish = 1'b0;
    tick(); tick();
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_idle",  64'(o_idle), 64'd1);
    chk("rst_en",    64'(pe.o_en), 64'd0);
    chk("rst_valid", 64'(pe.o_valid), 64'd0);
    chk("rst_instr", 64'(pe.o_instr), 64'd0);
    chk("rst_done",  64'(o_done), 64'd0);
    chk("rst_err",   64'(o_err), 64'd0);
    rstn = 1'b1;
    tick();

    // single command, ack tied high
    pe.i_ack = 1'b1;
    push_cmd(mk(2'd0, 16'd8, 32'h100, 32'h200, 32'h300));
    wait_xfer(4);
    chk("single_en", 64'(en_cnt), 64'd1);
    chk("setup_latency", 64'(st_cyc - en_cyc), 64'd7);
    tick(); tick(); tick(); tick();
    chk("wait_valid_low", 64'(pe.o_valid), 64'd0);
    finish_pulse();
    chk("fack_done",  64'(o_done), 64'd1);
    chk("fack_valid", 64'(pe.o_valid), 64'd1);
    chk("fack_instr", 64'(pe.o_instr), 64'd0);
    tick();
    chk("after_done", 64'(o_done), 64'd0);
    chk("single_done_cnt", 64'(done_cnt), 64'd1);
    chk("single_idle", 64'(o_idle), 64'd1);

    // back-pressure in LD1
    pe.i_ack = 1'b0;
    push_cmd(mk(2'd1, 16'd3, 32'h1100, 32'h200, 32'h1300));
    wait_valid();
    pe.i_ack = 1'b1;
    tick();
    pe.i_ack = 1'b0;
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 64'(pe.o_valid), 64'd1);
      chk("bp_instr", 64'(pe.o_instr), 64'({INSTR_LD, 32'h200}));
      tick();
    end
    chk("bp_xfer", 64'(xfer_cnt), 64'd5);
    pe.i_ack = 1'b1;
    wait_xfer(8);
    retire();
    chk("bp_done_cnt", 64'(done_cnt), 64'd2);

    // count==0 is dropped with an error pulse
    en0 = en_cnt;
    push_cmd(mk(2'd2, 16'd0, 32'h1, 32'h2, 32'h3));
    chk("zero_err_pulse", 64'(o_err), 64'd1);
    tick();
    chk("zero_err_clear", 64'(o_err), 64'd0);
    chk("zero_idle", 64'(o_idle), 64'd1);
    tick(); tick(); tick();
    chk("zero_no_en", 64'(en_cnt), 64'(en0));
    chk("zero_err_cnt", 64'(err_cnt), 64'd1);

    // stray finish outside WAIT is ignored
    d0 = done_cnt;
    finish_pulse();
    tick();
    chk("stray_finish", 64'(done_cnt), 64'(d0));

    // queue full while the PE sits in WAIT
    base = xfer_cnt;
    d0 = done_cnt;
    push_cmd(mk(2'd3, 16'd5, 32'h4000, 32'h4100, 32'hA000));
    wait_xfer(base + 4);
    for (int k = 0; k < 6; k++)
      cq[k] = mk(2'(k), 16'(k + 1), 32'h5000 + 32'(k), 32'h6000 + 32'(k), 32'hB000 + 32'(k));
    for (int k = 0; k < 4; k++) push_cmd(cq[k]);
    chk("full_ready", 64'(o_cmd_ready), 64'd0);
    chk("full_not_idle", 64'(o_idle), 64'd0);
    i_cmd_valid = 1'b1;
    i_cmd = cq[4];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_off", 64'(o_cmd_ready), 64'd0);
    end
    finish_pulse();
    begin
      int n = 0;
      while (!o_cmd_ready && n < 20) begin tick(); n++; end
    end
    chk("fifth_ready", 64'(o_cmd_ready), 64'd1);
    add_exp(cq[4]);
    tick();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_xfer(base + 4 * (k + 2));
      retire();
    end
    chk("full_done_cnt", 64'(done_cnt), 64'(d0 + 6));
    chk("full_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("full_idle", 64'(o_idle), 64'd1);

    // reset asserted while INFO is pending
    base = xfer_cnt;
    en0 = en_cnt;
    pe.i_ack = 1'b1;
    push_cmd(mk(2'd1, 16'd9, 32'h7000, 32'h7100, 32'h7200));
    begin
      int n = 0;
      while (xfer_cnt < base + 2 && n < 50) begin tick(); n++; end
    end
    pe.i_ack = 1'b0;
    wait_valid();
    chk("rst_mid_info", 64'(pe.o_instr.opcode), 64'(INSTR_INFO));
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(pe.o_valid), 64'd0);
    chk("arst_instr", 64'(pe.o_instr), 64'd0);
    chk("arst_en",    64'(pe.o_en), 64'd0);
    chk("arst_done",  64'(o_done), 64'd0);
    chk("arst_err",   64'(o_err), 64'd0);
    chk("arst_ready", 64'(o_cmd_ready), 64'd1);
    chk("arst_idle",  64'(o_idle), 64'd1);
    exp_q.delete();
    tick(); tick();
    rstn = 1'b1;
    pe.i_ack = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_xfer", 64'(xfer_cnt), 64'(base + 2));
    chk("post_rst_en", 64'(en_cnt), 64'(en0 + 1));
    chk("post_rst_idle", 64'(o_idle), 64'd1);

`ifdef CMD_ISSUER_PERF_EN
    chk("perf_rst_lat", 64'(o_lat), 64'd0);
    chk("perf_rst_ret", 64'(o_retired), 64'd0);
    en0 = en_cnt;
    base = xfer_cnt;
    push_cmd(mk(2'd2, 16'd4, 32'h8000, 32'h8100, 32'h8200));
    wait_xfer(base + 4);
    begin
      int n = 0;
      while (cyc < en_cyc + 20 && n < 50) begin tick(); n++; end
    end
    finish_pulse();
    tick();
    chk("perf_lat", 64'(o_lat), 64'd20);
    chk("perf_ret", 64'(o_retired), 64'd1);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
